// File: rtl/cpu_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package cpu_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] RESET_PC   = 32'd0;
  localparam logic [31:0] HALT_PC    = 32'd100;
  localparam int          IMEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    HALT     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer (master) and the pipeline/memory side (slave).
interface fetch_sequencer_if #(parameter int AW = 10);

  logic          stall;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [AW-1:0] imem_addr;
  logic          imem_rd_en;
  logic [31:0]   pc;
  logic [31:0]   pc_out;
  logic [31:0]   pc_plus4;
  logic          fetch_valid;
  logic          if_id_flush;
  logic          halted;
  logic          target_err;

  modport master (
    input  stall, branch_taken, branch_target,
    output imem_addr, imem_rd_en, pc, pc_out, pc_plus4,
           fetch_valid, if_id_flush, halted, target_err
  );

  modport slave (
    output stall, branch_taken, branch_target,
    input  imem_addr, imem_rd_en, pc, pc_out, pc_plus4,
           fetch_valid, if_id_flush, halted, target_err
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection and branch-target validity check for the fetch sequencer.
module fetch_next_pc #(
  parameter logic [31:0] HALT_PC    = cpu_pkg::HALT_PC,
  parameter int          IMEM_DEPTH = cpu_pkg::IMEM_DEPTH
) (
  input  cpu_pkg::fetch_state_e i_state,
  input  logic [31:0]           i_pc,
  input  logic                  i_stall,
  input  logic                  i_branchTaken,
  input  logic [31:0]           i_branchTarget,
  output logic [31:0]           o_nextPc,
  output logic                  o_atEnd,
  output logic                  o_takeBranch,
  output logic                  o_badTarget,
  output logic                  o_advance
);
  import cpu_pkg::*;

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

  logic w_active;

  // Priority: end-of-program halt beats a branch, a branch beats stall.
  always_comb begin
    w_active     = (i_state != HALT);
    o_atEnd      = w_active && (i_pc == HALT_PC);
    o_badTarget  = (i_branchTarget[1:0] != 2'b00) || (i_branchTarget >= IMEM_BYTES);
    o_takeBranch = w_active && !o_atEnd && i_branchTaken;
    o_advance    = w_active && !o_atEnd && !i_branchTaken && !i_stall;
    o_nextPc     = i_pc;
    if (o_takeBranch && !o_badTarget) begin
      o_nextPc = i_branchTarget;
    end else if (o_advance) begin
      o_nextPc = i_pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, drives the synchronous instruction memory
// and qualifies its output, flushing IF/ID on redirects and halting cleanly.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] HALT_PC    = cpu_pkg::HALT_PC,
  parameter int          IMEM_DEPTH = cpu_pkg::IMEM_DEPTH,
  parameter int          AW         = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  import cpu_pkg::*;

  fetch_state_e r_state, w_stateNext;
  logic [31:0]  r_pc, r_pcOut, r_pcPlus4;
  logic         r_fetchValid, r_ifIdFlush, r_halted, r_targetErr;

  logic [31:0]  w_nextPc;
  logic         w_atEnd, w_takeBranch, w_badTarget, w_advance;

  fetch_next_pc #(
    .HALT_PC    (HALT_PC),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_nextPc (
    .i_state        (r_state),
    .i_pc           (r_pc),
    .i_stall        (bus.stall),
    .i_branchTaken  (bus.branch_taken),
    .i_branchTarget (bus.branch_target),
    .o_nextPc       (w_nextPc),
    .o_atEnd        (w_atEnd),
    .o_takeBranch   (w_takeBranch),
    .o_badTarget    (w_badTarget),
    .o_advance      (w_advance)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      RUN, REDIRECT: begin
        if (w_atEnd)           w_stateNext = HALT;
        else if (w_takeBranch) w_stateNext = w_badTarget ? HALT : REDIRECT;
        else if (w_advance)    w_stateNext = RUN;
      end
      HALT:    w_stateNext = HALT;
      default: w_stateNext = HALT;
    endcase
  end

  // A stalled cycle leaves pc_out/fetch_valid alone so the memory output stays presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_pcOut      <= 32'd0;
      r_pcPlus4    <= 32'd4;
      r_fetchValid <= 1'b0;
      r_ifIdFlush  <= 1'b0;
      r_halted     <= 1'b0;
      r_targetErr  <= 1'b0;
    end else begin
      r_pc        <= w_nextPc;
      r_ifIdFlush <= w_takeBranch;
      if (w_advance) begin
        r_pcOut      <= r_pc;
        r_pcPlus4    <= r_pc + 32'd4;
        r_fetchValid <= 1'b1;
      end else if (r_state == HALT || w_atEnd || w_takeBranch) begin
        r_fetchValid <= 1'b0;
      end
      if (w_atEnd || (w_takeBranch && w_badTarget)) r_halted <= 1'b1;
      if (w_takeBranch && w_badTarget)              r_targetErr <= 1'b1;
    end
  end

  assign bus.imem_addr   = r_pc[AW+1:2];
  assign bus.imem_rd_en  = w_advance;
  assign bus.pc          = r_pc;
  assign bus.pc_out      = r_pcOut;
  assign bus.pc_plus4    = r_pcPlus4;
  assign bus.fetch_valid = r_fetchValid;
  assign bus.if_id_flush = r_ifIdFlush;
  assign bus.halted      = r_halted;
  assign bus.target_err  = r_targetErr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a cycle-level behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_PC   = 32'd100;
  localparam logic [31:0] MEM_BYTES = 32'd4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  fetch_sequencer_if #(.AW(10)) bus();

  fetch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the IF stage should look like from the outside.
  logic [31:0] mPc, mPcOut;
  bit          mValid, mFlush, mStopped, mErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc = 32'd0; mPcOut = 32'd0;
    mValid = 0; mFlush = 0; mStopped = 0; mErr = 0;
  endtask

  function automatic bit expectRead(input bit st, input bit br);
    return !mStopped && (mPc != HALT_PC) && !br && !st;
  endfunction

  task automatic checkAll(input bit st, input bit br);
    checkOutput("imem_rd_en",  32'(bus.imem_rd_en),  32'(expectRead(st, br)));
    checkOutput("imem_addr",   32'(bus.imem_addr),   32'(mPc[11:2]));
    checkOutput("pc",          bus.pc,               mPc);
    checkOutput("pc_out",      bus.pc_out,           mPcOut);
    checkOutput("pc_plus4",    bus.pc_plus4,         mPcOut + 32'd4);
    checkOutput("fetch_valid", 32'(bus.fetch_valid), 32'(mValid));
    checkOutput("if_id_flush", 32'(bus.if_id_flush), 32'(mFlush));
    checkOutput("halted",      32'(bus.halted),      32'(mStopped));
    checkOutput("target_err",  32'(bus.target_err),  32'(mErr));
  endtask

  // Advance the model across one rising edge given the inputs seen in that cycle.
  task automatic modelStep(input bit st, input bit br, input logic [31:0] tgt);
    bit bad;
    bad = (tgt[1:0] != 2'b00) || (tgt >= MEM_BYTES);
    mFlush = 0;
    if (mStopped) begin
      mValid = 0;
    end else if (mPc == HALT_PC) begin
      mStopped = 1; mValid = 0;
    end else if (br) begin
      mFlush = 1; mValid = 0;
      if (bad) begin
        mStopped = 1; mErr = 1;
      end else begin
        mPc = tgt;
      end
    end else if (!st) begin
      mPcOut = mPc; mPc = mPc + 32'd4; mValid = 1;
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    modelReset();
    #1;
    checkAll(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pickTarget();
    int r;
    r = $urandom_range(0, 99);
    if (r < 6)  return 32'($urandom_range(0, 24)) * 32'd4 + 32'd2;
    if (r < 10) return MEM_BYTES + 32'($urandom_range(0, 500)) * 32'd4;
    if (r < 12) return 32'hFFFF_FFFC;
    if (r < 18) return HALT_PC;
    return 32'($urandom_range(0, 24)) * 32'd4;
  endfunction

  // Runs from a negedge and ends on a negedge.
  task automatic applyStimulus(input int cycles, input int stallPct, input int brPct);
    bit st, br;
    logic [31:0] tgt;
    for (int c = 0; c < cycles; c++) begin
      st  = ($urandom_range(0, 99) < stallPct);
      br  = ($urandom_range(0, 99) < brPct);
      tgt = pickTarget();
      bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt;
      #1;
      checkAll(st, br);
      @(posedge clk);
      modelStep(st, br, tgt);
      @(negedge clk);
    end
    bus.stall = 1'b0; bus.branch_taken = 1'b0;
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    @(negedge clk);

    resetDut();
    applyStimulus(35, 0, 0);
    applyStimulus(10, 30, 50);

    for (int e = 0; e < 24; e++) begin
      resetDut();
      applyStimulus(50, (e % 4) * 12, 3 + (e % 3) * 4);
    end

    // Asynchronous reset landing in the redirect bubble.
    resetDut();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    @(posedge clk);
    bus.branch_taken = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_pc",     bus.pc,                   32'd0);
    checkOutput("async_valid",  32'(bus.fetch_valid),     32'd0);
    checkOutput("async_halted", 32'(bus.halted),          32'd0);
    checkOutput("async_flush",  32'(bus.if_id_flush),     32'd0);
    @(negedge clk);
    modelReset();
    reset = 1'b0;
    applyStimulus(40, 20, 5);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
